mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter RR, default 1, arbitration mode: 1 = round-robin, 0 = fixed priority with port 0 winning.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0, req1  input  1 each  access request from port 0 (CPU) and port 1 (loader).
REQ-005 we0, we1  input  1 each  1 = write, 0 = read; sampled with req.
REQ-006 addr0, addr1  input  8 each  memory address.
REQ-007 wdata0, wdata1  input  8 each  write data.
REQ-008 gnt0, gnt1  output  1 each  one-cycle pulse: the command was accepted and is being issued to memory.
REQ-009 rvalid0, rvalid1  output  1 each  one-cycle pulse: read data valid.
REQ-010 rdata  output  8  read data, shared by both ports, qualified by rvalid0/rvalid1.
REQ-011 mem_en, mem_we  output  1 each  memory enable and write enable.
REQ-012 mem_addr, mem_wdata  output  8 each  memory address and write data.
REQ-013 mem_rdata  input  8  memory read data, valid one cycle after a read with mem_en=1.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ACCESS and RESP.
REQ-016 IDLE: with no req, stay in IDLE; with any req, select a winner, latch its we/addr/wdata into internal command registers and the winner id, go to ACCESS.
REQ-017 Round-robin (RR=1): single req wins; if both req, the port not granted last wins; the last-grant pointer updates on every IDLE->ACCESS transition.
REQ-018 Fixed priority (RR=0): port 0 wins whenever req0=1.
REQ-019 ACCESS (exactly one cycle): mem_en=1, mem_we=latched we, mem_addr/mem_wdata from the command registers; gnt of the winner =1, other gnt=0.
REQ-020 ACCESS -> RESP on read; ACCESS -> IDLE on write.
REQ-021 RESP (exactly one cycle): rvalid of the winner =1, rdata = mem_rdata; next state IDLE.
REQ-022 Latency from req sampled high in IDLE (cycle N): gnt in N+1; rvalid in N+2 (read); next arbitration in N+2 (write) or N+3 (read).
REQ-023 Outside ACCESS: mem_en=0, mem_we=0. Outside RESP: rvalid0=rvalid1=0. rdata is don't-care when no rvalid is high.
REQ-024 req, we, addr and wdata SHALL be sampled only in IDLE; changes in ACCESS/RESP are ignored; a requester drops req after seeing gnt, otherwise the held req is treated as a new request.
REQ-025 At most one of gnt0/gnt1 and at most one of rvalid0/rvalid1 SHALL be high in any cycle.
REQ-026 A request from the losing port remains pending (no loss) and is served at the next IDLE, subject to the arbitration mode.
REQ-027 Address and data pass through unmodified, with no arithmetic; wrap at 8'hFF is the memory's concern.

Reset
REQ-028 rst_n=0 SHALL immediately force: state IDLE; last-grant pointer = 1 (port 0 wins the first tie); command registers 0; all outputs 0, including busy.
REQ-029 Reset asserted mid-ACCESS or mid-RESP aborts the transaction: no gnt/rvalid after reset and no write issued; operation resumes in IDLE on the first edge after release.

Verification
REQ-030 Reset, then req0=1, we0=0, addr0=8'h10 with memory[8'h10]=8'h2A -> gnt0 one cycle later, rvalid0 with rdata=8'h2A the following cycle, busy high for 2 cycles.
REQ-031 req1 write, addr1=8'h05, wdata1=8'h77 -> gnt1 with mem_en=1, mem_we=1, mem_addr=8'h05, mem_wdata=8'h77 in the same cycle, no rvalid, IDLE next cycle.
REQ-032 RR=1, req0 and req1 held continuously (reads) -> grants alternate 0,1,0,1 starting with port 0, one every 3 cycles.
REQ-033 RR=0, both req held -> port 0 granted every time and port 1 starved; drop req0 -> port 1 granted at the next IDLE.
REQ-034 rst_n pulsed low during ACCESS of a write -> mem_en/mem_we drop immediately, no gnt/rvalid follows, busy=0, and the next req is served normally.
REQ-035 addr0 changed during ACCESS -> mem_addr keeps the value latched in IDLE; port 0 write to 8'hFF -> mem_addr=8'hFF.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Two-port memory arbiter bus: requester handshakes plus the single memory port.
interface mem_arbiter_if;
    logic       req0;
    logic       req1;
    logic       we0;
    logic       we1;
    logic [7:0] addr0;
    logic [7:0] addr1;
    logic [7:0] wdata0;
    logic [7:0] wdata1;
    logic       gnt0;
    logic       gnt1;
    logic       rvalid0;
    logic       rvalid1;
    logic [7:0] rdata;
    logic       mem_en;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;

    // Arbiter side
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    // Requesters and memory side
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: round-robin or fixed-priority selection, one command
// in flight, IDLE -> ACCESS (one cycle) -> RESP (reads only) -> IDLE.
module mem_arbiter #(
    parameter bit RR = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t     state_r;
    state_t     nxt_state_s;
    logic       load_s;
    logic       win_s;
    logic       sel_we_s;
    logic [7:0] sel_addr_s;
    logic [7:0] sel_wdata_s;
    logic       last_r;
    logic       winner_r;
    logic       cmd_we_r;
    logic [7:0] cmd_addr_r;
    logic [7:0] cmd_wdata_r;

    // Pick the winning port and mux its command fields
    always_comb begin
        win_s = 1'b0;
        if (RR) begin
            if (bus.req0 && bus.req1) begin
                win_s = ~last_r;
            end else if (bus.req1) begin
                win_s = 1'b1;
            end else begin
                win_s = 1'b0;
            end
        end else begin
            if (bus.req0) begin
                win_s = 1'b0;
            end else if (bus.req1) begin
                win_s = 1'b1;
            end else begin
                win_s = 1'b0;
            end
        end
        if (win_s) begin
            sel_we_s    = bus.we1;
            sel_addr_s  = bus.addr1;
            sel_wdata_s = bus.wdata1;
        end else begin
            sel_we_s    = bus.we0;
            sel_addr_s  = bus.addr0;
            sel_wdata_s = bus.wdata0;
        end
    end

    // Next-state logic; load_s marks the IDLE->ACCESS command capture
    always_comb begin
        nxt_state_s = state_r;
        load_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    nxt_state_s = ACCESS;
                    load_s      = 1'b1;
                end else begin
                    nxt_state_s = IDLE;
                end
            end
            ACCESS: begin
                if (cmd_we_r) begin
                    nxt_state_s = IDLE;
                end else begin
                    nxt_state_s = RESP;
                end
            end
            RESP:    nxt_state_s = IDLE;
            default: nxt_state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= nxt_state_s;
        end
    end

    // Command registers and last-grant pointer, captured when a request is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r      <= 1'b1;
            winner_r    <= 1'b0;
            cmd_we_r    <= 1'b0;
            cmd_addr_r  <= 8'h00;
            cmd_wdata_r <= 8'h00;
        end else if (load_s) begin
            last_r      <= win_s;
            winner_r    <= win_s;
            cmd_we_r    <= sel_we_s;
            cmd_addr_r  <= sel_addr_s;
            cmd_wdata_r <= sel_wdata_s;
        end
    end

    // Registered outputs, computed one cycle ahead so they line up with the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.gnt0      <= 1'b0;
            bus.gnt1      <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 8'h00;
            bus.mem_wdata <= 8'h00;
            bus.rvalid0   <= 1'b0;
            bus.rvalid1   <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.gnt0      <= load_s & ~win_s;
            bus.gnt1      <= load_s & win_s;
            bus.mem_en    <= load_s;
            bus.mem_we    <= load_s & sel_we_s;
            bus.mem_addr  <= load_s ? sel_addr_s : 8'h00;
            bus.mem_wdata <= load_s ? sel_wdata_s : 8'h00;
            bus.rvalid0   <= (state_r == ACCESS) & ~cmd_we_r & ~winner_r;
            bus.rvalid1   <= (state_r == ACCESS) & ~cmd_we_r & winner_r;
            bus.busy      <= (nxt_state_s != IDLE);
        end
    end

    // Memory read data arrives during RESP, so it is passed straight through
    assign bus.rdata = (bus.rvalid0 | bus.rvalid1) ? bus.mem_rdata : 8'h00;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one round-robin and one fixed-priority instance driven
// with the same requests, each checked against a transaction-level model.
module tb_mem_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic       in_req0, in_req1, in_we0, in_we1;
    logic [7:0] in_addr0, in_addr1, in_wdata0, in_wdata1;

    mem_arbiter_if bus_rr ();
    mem_arbiter_if bus_fp ();

    mem_arbiter #(.RR(1'b1)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(bus_rr));
    mem_arbiter #(.RR(1'b0)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(bus_fp));

    assign bus_rr.req0 = in_req0;     assign bus_fp.req0 = in_req0;
    assign bus_rr.req1 = in_req1;     assign bus_fp.req1 = in_req1;
    assign bus_rr.we0 = in_we0;       assign bus_fp.we0 = in_we0;
    assign bus_rr.we1 = in_we1;       assign bus_fp.we1 = in_we1;
    assign bus_rr.addr0 = in_addr0;   assign bus_fp.addr0 = in_addr0;
    assign bus_rr.addr1 = in_addr1;   assign bus_fp.addr1 = in_addr1;
    assign bus_rr.wdata0 = in_wdata0; assign bus_fp.wdata0 = in_wdata0;
    assign bus_rr.wdata1 = in_wdata1; assign bus_fp.wdata1 = in_wdata1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 8'h2A : (a ^ 8'hA5);
    endfunction

    // Behavioural memories, reloaded with the known pattern while reset is low
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] rd_a, rd_b;
    assign bus_rr.mem_rdata = rd_a;
    assign bus_fp.mem_rdata = rd_b;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= init_val(8'(i));
            rd_a <= 8'h00;
        end else if (bus_rr.mem_en) begin
            if (bus_rr.mem_we) mem_a[bus_rr.mem_addr] <= bus_rr.mem_wdata;
            else               rd_a <= mem_a[bus_rr.mem_addr];
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= init_val(8'(i));
            rd_b <= 8'h00;
        end else if (bus_fp.mem_en) begin
            if (bus_fp.mem_we) mem_b[bus_fp.mem_addr] <= bus_fp.mem_wdata;
            else               rd_b <= mem_b[bus_fp.mem_addr];
        end
    end

    // Reference model (index 0 = round-robin instance, 1 = fixed priority)
    int         wait_c [2];
    logic       last [2];
    logic       rp [2], rp_win [2];
    logic [7:0] rp_addr [2];
    logic       wr_p [2];
    logic [7:0] wr_addr [2], wr_data [2];
    logic [7:0] refmem [2][256];
    logic       e_gnt0 [2], e_gnt1 [2], e_en [2], e_we [2];
    logic       e_rv0 [2], e_rv1 [2], e_busy [2];
    logic [7:0] e_addr [2], e_wdata [2], e_rdata [2];

    task automatic clear_exp(input int m);
        e_gnt0[m] = 1'b0; e_gnt1[m] = 1'b0; e_en[m] = 1'b0; e_we[m] = 1'b0;
        e_rv0[m] = 1'b0; e_rv1[m] = 1'b0; e_busy[m] = 1'b0;
        e_addr[m] = 8'h00; e_wdata[m] = 8'h00; e_rdata[m] = 8'h00;
    endtask

    task automatic model_reset(input int m);
        wait_c[m] = 0; last[m] = 1'b1; rp[m] = 1'b0; rp_win[m] = 1'b0;
        rp_addr[m] = 8'h00; wr_p[m] = 1'b0; wr_addr[m] = 8'h00; wr_data[m] = 8'h00;
        for (int i = 0; i < 256; i++) refmem[m][i] = init_val(8'(i));
        clear_exp(m);
    endtask

    // Advance the model across one rising edge; expectations describe the next cycle
    task automatic model_edge(input int m);
        logic w, we;
        logic [7:0] ad, wd;
        if (!rst_n) begin
            model_reset(m);
            return;
        end
        clear_exp(m);
        if (wr_p[m]) begin
            refmem[m][wr_addr[m]] = wr_data[m];
            wr_p[m] = 1'b0;
        end
        if (wait_c[m] == 0) begin
            if (in_req0 || in_req1) begin
                if (in_req0 && in_req1) w = (m == 0) ? ~last[m] : 1'b0;
                else                    w = in_req1;
                last[m] = w;
                we = w ? in_we1 : in_we0;
                ad = w ? in_addr1 : in_addr0;
                wd = w ? in_wdata1 : in_wdata0;
                e_gnt0[m] = ~w; e_gnt1[m] = w; e_en[m] = 1'b1; e_we[m] = we;
                e_addr[m] = ad; e_wdata[m] = wd; e_busy[m] = 1'b1;
                if (we) begin
                    wr_p[m] = 1'b1; wr_addr[m] = ad; wr_data[m] = wd; wait_c[m] = 1;
                end else begin
                    rp[m] = 1'b1; rp_win[m] = w; rp_addr[m] = ad; wait_c[m] = 2;
                end
            end
        end else begin
            wait_c[m] = wait_c[m] - 1;
            e_busy[m] = (wait_c[m] != 0);
            if (rp[m]) begin
                e_rv0[m] = ~rp_win[m];
                e_rv1[m] = rp_win[m];
                e_rdata[m] = refmem[m][rp_addr[m]];
                rp[m] = 1'b0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_bus(input int m, input logic g0, input logic g1,
                               input logic en, input logic we, input logic [7:0] ad,
                               input logic [7:0] wd, input logic rv0, input logic rv1,
                               input logic [7:0] rd, input logic bz);
        string p;
        p = (m == 0) ? "rr" : "fp";
        chk({p, ".gnt0"},   {7'd0, g0},  {7'd0, e_gnt0[m]});
        chk({p, ".gnt1"},   {7'd0, g1},  {7'd0, e_gnt1[m]});
        chk({p, ".mem_en"}, {7'd0, en},  {7'd0, e_en[m]});
        chk({p, ".mem_we"}, {7'd0, we},  {7'd0, e_we[m]});
        chk({p, ".rvalid0"}, {7'd0, rv0}, {7'd0, e_rv0[m]});
        chk({p, ".rvalid1"}, {7'd0, rv1}, {7'd0, e_rv1[m]});
        chk({p, ".busy"},   {7'd0, bz},  {7'd0, e_busy[m]});
        if (e_en[m]) begin
            chk({p, ".mem_addr"},  ad, e_addr[m]);
            chk({p, ".mem_wdata"}, wd, e_wdata[m]);
        end
        if (e_rv0[m] || e_rv1[m]) chk({p, ".rdata"}, rd, e_rdata[m]);
    endtask

    task automatic compare_all();
        compare_bus(0, bus_rr.gnt0, bus_rr.gnt1, bus_rr.mem_en, bus_rr.mem_we,
                    bus_rr.mem_addr, bus_rr.mem_wdata, bus_rr.rvalid0, bus_rr.rvalid1,
                    bus_rr.rdata, bus_rr.busy);
        compare_bus(1, bus_fp.gnt0, bus_fp.gnt1, bus_fp.mem_en, bus_fp.mem_we,
                    bus_fp.mem_addr, bus_fp.mem_wdata, bus_fp.rvalid0, bus_fp.rvalid1,
                    bus_fp.rdata, bus_fp.busy);
    endtask

    task automatic tick();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_in(input logic r0, input logic w0, input logic [7:0] a0,
                          input logic [7:0] d0, input logic r1, input logic w1,
                          input logic [7:0] a1, input logic [7:0] d1);
        in_req0 = r0; in_we0 = w0; in_addr0 = a0; in_wdata0 = d0;
        in_req1 = r1; in_we1 = w1; in_addr1 = a1; in_wdata1 = d1;
    endtask

    logic seq_q [$];
    int   fp_g0, fp_g1;

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        model_reset(0);
        model_reset(1);

        // Reset state
        tick();
        tick();
        rst_n = 1'b1;

        // Port 0 read of 8'h10
        set_in(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        in_req0 = 1'b0;
        tick();
        chk("read_2a.rdata", bus_rr.rdata, 8'h2A);
        chk("read_2a.busy", {7'd0, bus_rr.busy}, 8'h01);
        tick();

        // Port 1 write 8'h77 to 8'h05
        set_in(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h05, 8'h77);
        tick();
        chk("wr1.mem_addr", bus_rr.mem_addr, 8'h05);
        chk("wr1.mem_wdata", bus_rr.mem_wdata, 8'h77);
        in_req1 = 1'b0;
        tick();
        tick();

        // Both ports holding reads
        set_in(1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h05, 8'h00);
        fp_g0 = 0;
        fp_g1 = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus_rr.gnt0) seq_q.push_back(1'b0);
            if (bus_rr.gnt1) seq_q.push_back(1'b1);
            if (bus_fp.gnt0) fp_g0++;
            if (bus_fp.gnt1) fp_g1++;
        end
        chk("rr.grant_count", 8'(seq_q.size()), 8'd4);
        for (int i = 0; i < seq_q.size(); i++)
            chk("rr.grant_order", {7'd0, seq_q[i]}, {7'd0, 1'(i % 2)});
        chk("fp.port0_grants", 8'(fp_g0), 8'd4);
        chk("fp.port1_starved", 8'(fp_g1), 8'd0);
        in_req0 = 1'b0;
        tick();
        chk("fp.port1_after_drop", {7'd0, bus_fp.gnt1}, 8'h01);
        in_req1 = 1'b0;
        tick();
        tick();

        // Reset pulse during the ACCESS cycle of a write
        set_in(1'b1, 1'b1, 8'h33, 8'h99, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        in_req0 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        compare_all();
        chk("rst_mid.mem_en", {7'd0, bus_rr.mem_en}, 8'h00);
        tick();
        rst_n = 1'b1;
        set_in(1'b1, 1'b0, 8'h33, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        in_req0 = 1'b0;
        tick();
        tick();

        // Address change during ACCESS, write at the top address
        set_in(1'b1, 1'b1, 8'hFF, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        in_addr0 = 8'h00;
        in_req0 = 1'b0;
        chk("wr_ff.mem_addr", bus_rr.mem_addr, 8'hFF);
        tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                   8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                   8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
